// File: rtl/dbus_arb_pkg.sv
// dbus_arb_pkg: state encoding, master indices and default widths for dbus_arbiter
package dbus_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10} state_t;
    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: two-way round-robin picker; a tie goes to the master that did not own the bus last
module arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant_valid,
    output logic       grant_idx
);
    assign grant_valid = |req;
    assign grant_idx   = (req == 2'b11) ? ~last_owner : req[1];
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the Bridge data port between the MEM stage (m0) and an auxiliary master (m1).
// Optional BUSY watchdog enabled by defining DBUS_ARB_TIMEOUT_EN.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              m0_req,
    input  logic              m0_wen,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    output logic              m0_stall,
    input  logic              m1_req,
    input  logic              m1_wen,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              bus_req,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              owner,
    output logic              busy
);
    state_t            state_q, state_d;
    logic              last_owner_q, owner_q, bus_req_q, bus_wen_q, err_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q, rdata_q;
    logic              grant_valid, grant_idx, to_hit, grant, finish;

    arb_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_owner (last_owner_q),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

`ifdef DBUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) cnt_q <= '0;
        else          cnt_q <= (state_q == BUSY) ? cnt_q + 1'b1 : '0;
    end
    // an ack arriving on the limit cycle still completes normally
    assign to_hit = (state_q == BUSY) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign to_hit = 1'b0;
`endif

    assign grant  = (state_q == IDLE) && grant_valid;
    assign finish = (state_q == BUSY) && (bus_ack || to_hit);

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        state_d = grant ? BUSY : finish ? RESP : (state_q == RESP) ? IDLE : state_q;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_wen_q    <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (grant) begin
                owner_q     <= grant_idx;
                bus_req_q   <= 1'b1;
                bus_wen_q   <= grant_idx ? m1_wen : m0_wen;
                bus_addr_q  <= grant_idx ? m1_addr : m0_addr;
                bus_wdata_q <= grant_idx ? m1_wdata : m0_wdata;
            end
            if (finish) begin
                bus_req_q    <= 1'b0;
                last_owner_q <= owner_q;
                rdata_q      <= to_hit ? DATA_W'(TIMEOUT_DATA) : bus_wen_q ? '0 : bus_rdata;
                err_q        <= to_hit;
            end
        end
    end

    assign m0_done   = (state_q == RESP) && (owner_q == M_CPU);
    assign m1_done   = (state_q == RESP) && (owner_q == M_AUX);
    assign m0_rdata  = m0_done ? rdata_q : '0;
    assign m1_rdata  = m1_done ? rdata_q : '0;
    assign m0_err    = m0_done & err_q;
    assign m1_err    = m1_done & err_q;
    assign m0_stall  = m0_req & ~m0_done;
    assign bus_req   = bus_req_q;
    assign bus_wen   = bus_wen_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed scoreboard bench for dbus_arbiter; timeout steps need DBUS_ARB_TIMEOUT_EN
module tb_dbus_arbiter;
    localparam logic [31:0] K = 32'h1234_5778;
    logic        clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        m0_req = 0, m0_wen = 0, m1_req = 0, m1_wen = 0, bus_ack = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_done, m0_err, m0_stall, m1_done, m1_err, bus_req, bus_wen, owner, busy;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;

    typedef struct packed {logic idx; logic [31:0] rdata; logic err;} exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, m1_pulses = 0, p0 = 0;

    always #5 clk = ~clk;
    assign bus_rdata = bus_addr ^ K;

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .cpu_clk(clk), .cpu_rst(cpu_rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .owner(owner), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic i, input logic [31:0] d, input logic e);
        sb.push_back({i, d, e});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (cpu_rst && (m0_done || m1_done)) begin
            chk("one_done", {31'b0, m0_done & m1_done}, 32'd0);
            if (m1_done) m1_pulses++;
            chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_idx", {31'b0, m1_done}, {31'b0, e.idx});
                chk("rdata", m1_done ? m1_rdata : m0_rdata, e.rdata);
                chk("err", {31'b0, m1_done ? m1_err : m0_err}, {31'b0, e.err});
                chk("nonowner_rdata", m1_done ? m0_rdata : m1_rdata, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(posedge clk);
        smp;
        chk("rst_bus_req", {31'b0, bus_req}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_owner", {31'b0, owner}, 0);
        chk("rst_done", {30'b0, m1_done, m0_done}, 0);
        chk("rst_stall", {31'b0, m0_stall}, 0);
        cpu_rst = 1'b1;
        // single CPU read, ack in first BUSY cycle
        tick; m0_req = 1; m0_wen = 0; m0_addr = 32'h100; push(0, 32'h1234_5678, 0);
        smp; chk("t1_c0_bus_req", {31'b0, bus_req}, 0); chk("t1_c0_stall", {31'b0, m0_stall}, 1);
        tick; bus_ack = 1;
        smp; chk("t1_bus_req", {31'b0, bus_req}, 1); chk("t1_bus_addr", bus_addr, 32'h100);
        chk("t1_bus_wen", {31'b0, bus_wen}, 0); chk("t1_c1_stall", {31'b0, m0_stall}, 1);
        tick; bus_ack = 0;
        smp; chk("t1_done", {31'b0, m0_done}, 1); chk("t1_c2_stall", {31'b0, m0_stall}, 0);
        chk("t1_c2_bus_req", {31'b0, bus_req}, 0);
        m0_req = 0;
        tick; smp; chk("t1_idle", {31'b0, busy}, 0); chk("t1_c3_stall", {31'b0, m0_stall}, 0);
        // reset mid-transaction, then a tie after release
        tick; m1_req = 1; m1_wen = 0; m1_addr = 32'h200;
        tick; smp; chk("t5_bus_req", {31'b0, bus_req}, 1); chk("t5_owner", {31'b0, owner}, 1);
        #2 cpu_rst = 0;
        #1 chk("t5_async_bus_req", {31'b0, bus_req}, 0); chk("t5_async_busy", {31'b0, busy}, 0);
        chk("t5_async_done", {30'b0, m1_done, m0_done}, 0); chk("t5_async_owner", {31'b0, owner}, 0);
        chk("t5_async_addr", bus_addr, 0);
        m0_req = 1; m0_wen = 0; m0_addr = 32'h300;
        @(negedge clk); cpu_rst = 1; bus_ack = 1; push(0, 32'h300 ^ K, 0);
        tick; smp; chk("t5_tie_owner", {31'b0, owner}, 0); chk("t5_tie_addr", bus_addr, 32'h300);
        tick; smp; chk("t5_done0", {31'b0, m0_done}, 1);
        m0_req = 0; m1_req = 0; bus_ack = 0;
        tick; smp; chk("t5_idle", {31'b0, busy}, 0);
        cpu_rst = 0; tick; cpu_rst = 1;
        // simultaneous requests held high, immediate ack
        tick; m0_req = 1; m1_req = 1; m0_addr = 32'h400; m1_addr = 32'h500; bus_ack = 1;
        push(0, 32'h400 ^ K, 0); push(1, 32'h500 ^ K, 0); push(0, 32'h400 ^ K, 0); push(1, 32'h500 ^ K, 0);
        for (int c = 0; c < 12; c++) begin
            smp;
            chk($sformatf("t2_done0_c%0d", c), {31'b0, m0_done}, {31'b0, c == 2 || c == 8});
            chk($sformatf("t2_done1_c%0d", c), {31'b0, m1_done}, {31'b0, c == 5 || c == 11});
            if (c % 3 == 1) chk($sformatf("t2_owner_c%0d", c), {31'b0, owner}, {31'b0, c == 4 || c == 10});
            tick;
        end
        m0_req = 0; m1_req = 0; bus_ack = 0;
        smp; chk("t2_idle", {31'b0, busy}, 0);
        // delayed write from m1
        tick; m1_req = 1; m1_wen = 1; m1_addr = 32'hFFFF_F000; m1_wdata = 32'hA5A5_A5A5; push(1, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            tick; if (c == 5) bus_ack = 1;
            smp;
            chk($sformatf("t3_bus_req_c%0d", c), {31'b0, bus_req}, 1);
            chk($sformatf("t3_bus_wen_c%0d", c), {31'b0, bus_wen}, 1);
            chk($sformatf("t3_bus_addr_c%0d", c), bus_addr, 32'hFFFF_F000);
            chk($sformatf("t3_bus_wdata_c%0d", c), bus_wdata, 32'hA5A5_A5A5);
            chk($sformatf("t3_done_c%0d", c), {31'b0, m1_done}, 0);
        end
        tick; bus_ack = 0;
        smp; chk("t3_done1", {31'b0, m1_done}, 1);
        m1_req = 0; m1_wen = 0;
        tick; smp; chk("t3_idle", {31'b0, busy}, 0);
        // request withdrawn during BUSY
        tick; m1_req = 1; m1_addr = 32'h40; push(1, 32'h40 ^ K, 0); p0 = m1_pulses;
        tick; m1_req = 0; smp; chk("t4_busy", {31'b0, busy}, 1);
        tick; bus_ack = 1; smp; chk("t4_bus_req", {31'b0, bus_req}, 1);
        tick; bus_ack = 0; smp; chk("t4_done1", {31'b0, m1_done}, 1);
        for (int c = 0; c < 3; c++) begin
            tick; smp; chk($sformatf("t4_no_replay_%0d", c), {31'b0, busy}, 0);
        end
        chk("t4_pulses", m1_pulses - p0, 1);
`ifdef DBUS_ARB_TIMEOUT_EN
        tick; m0_req = 1; m0_wen = 0; m0_addr = 32'h600; push(0, 32'hDEAD_BEEF, 1);
        for (int c = 1; c <= 8; c++) begin
            tick; smp; chk($sformatf("to_bus_req_c%0d", c), {31'b0, bus_req}, 1);
        end
        tick; smp; chk("to_done", {31'b0, m0_done}, 1); chk("to_err", {31'b0, m0_err}, 1);
        chk("to_bus_req_drop", {31'b0, bus_req}, 0);
        m0_req = 0;
        tick;
        tick; m0_req = 1; push(0, 32'h600 ^ K, 0);
        for (int c = 1; c <= 8; c++) begin
            tick; if (c == 8) bus_ack = 1;
            smp; chk($sformatf("to2_bus_req_c%0d", c), {31'b0, bus_req}, 1);
        end
        tick; bus_ack = 0; smp; chk("to2_done", {31'b0, m0_done}, 1); chk("to2_err", {31'b0, m0_err}, 0);
        m0_req = 0;
        tick;
`endif
        tick; smp;
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
